// File: rtl/sym_index_gen.sv
// Pseudo-random 4-bit symbol index generator: 16-bit Galois LFSR with request/valid handshake and round counter.
// Optional macro SYMIDX_NOREPEAT_EN forbids two consecutive equal indices.
module sym_index_gen #(
   parameter logic [15:0] DEFAULT_SEED  = 16'hACE1,
   parameter int unsigned STEPS_PER_IDX = 4,
   parameter int unsigned ROUND_LEN     = 10
) (
   input  logic        ClkSymGen,
   input  logic        Reset,
   input  logic        NextReq,
   input  logic        SeedLoad,
   input  logic [15:0] Seed,
   output logic [3:0]  randomNum,
   output logic        IdxValid,
   output logic        Busy,
   output logic [7:0]  IssuedCount,
   output logic        RoundDone
);

   localparam int unsigned LFSR_W = 16;
   localparam int unsigned IDX_W  = 4;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned STEP_W = 4;
   localparam logic [LFSR_W-1:0] TAPS      = 16'hB400;
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS_PER_IDX - 1);
   localparam logic [CNT_W-1:0]  ROUND_END = CNT_W'(ROUND_LEN);

   typedef enum logic [1:0] {IDLE, STEP, CHECK} state_t;

   state_t              state;
   logic [LFSR_W-1:0]   lfsr;
   logic [STEP_W-1:0]   step_cnt;
   logic [IDX_W-1:0]    emit_idx;
   logic [CNT_W-1:0]    issued_inc;
   logic                round_wrap;
`ifdef SYMIDX_NOREPEAT_EN
   logic [IDX_W-1:0]    last;
   logic [1:0]          retries;
   logic                retry_c;
`endif

   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
      return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
   endfunction

   // Index chosen in CHECK, plus retry decision when repeats are forbidden
   always_comb begin
      emit_idx = lfsr[IDX_W-1:0];
`ifdef SYMIDX_NOREPEAT_EN
      retry_c = 1'b0;
      if (lfsr[IDX_W-1:0] == last) begin
         if (retries < 2'd3) retry_c = 1'b1;
         else                emit_idx = last + 4'd1;
      end
`endif
   end

   assign issued_inc = IssuedCount + 8'd1;
   assign round_wrap = (issued_inc == ROUND_END);

   always_ff @(posedge ClkSymGen) begin
      if (Reset) begin
         state       <= IDLE;
         lfsr        <= DEFAULT_SEED;
         step_cnt    <= '0;
         randomNum   <= '0;
         IdxValid    <= 1'b0;
         Busy        <= 1'b0;
         IssuedCount <= '0;
         RoundDone   <= 1'b0;
`ifdef SYMIDX_NOREPEAT_EN
         last        <= '0;
         retries     <= '0;
`endif
      end else if (SeedLoad) begin
         // Zero seed would lock the LFSR, so the default is substituted
         lfsr        <= (Seed == 16'h0000) ? DEFAULT_SEED : Seed;
         state       <= IDLE;
         step_cnt    <= '0;
         IdxValid    <= 1'b0;
         Busy        <= 1'b0;
         IssuedCount <= '0;
         RoundDone   <= 1'b0;
      end else begin
         IdxValid  <= 1'b0;
         RoundDone <= 1'b0;
         case (state)
            IDLE: begin
               if (NextReq) begin
                  state    <= STEP;
                  step_cnt <= '0;
                  Busy     <= 1'b1;
`ifdef SYMIDX_NOREPEAT_EN
                  retries  <= '0;
`endif
               end
            end
            STEP: begin
               lfsr <= lfsr_step(lfsr);
               if (step_cnt == LAST_STEP) state    <= CHECK;
               else                       step_cnt <= step_cnt + 4'd1;
            end
            CHECK: begin
`ifdef SYMIDX_NOREPEAT_EN
               if (retry_c) begin
                  lfsr    <= lfsr_step(lfsr);
                  retries <= retries + 2'd1;
               end else begin
                  last <= emit_idx;
`endif
                  randomNum <= emit_idx;
                  IdxValid  <= 1'b1;
                  Busy      <= 1'b0;
                  state     <= IDLE;
                  if (round_wrap) begin
                     IssuedCount <= '0;
                     RoundDone   <= 1'b1;
                  end else begin
                     IssuedCount <= issued_inc;
                  end
`ifdef SYMIDX_NOREPEAT_EN
               end
`endif
            end
            default: begin
               state <= IDLE;
               Busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
